// File: rtl/sshr_share_ctrl_if.sv
// Bundle of the two request channels and the response channel of the
// shared arithmetic right shifter.
//
// Handshake rule, same on every channel: a transfer happens on a rising
// clock edge where valid and ready are both high. The sender keeps valid
// and its payload stable until that edge. Ready may depend combinationally
// on valid. Valid never depends on ready.
interface sshr_share_ctrl_if #(
    parameter int DATAWIDTH = 8
);
    logic                 req0_valid;
    logic [DATAWIDTH-1:0] req0_a;
    logic [DATAWIDTH-1:0] req0_sh;
    logic                 req0_ready;

    logic                 req1_valid;
    logic [DATAWIDTH-1:0] req1_a;
    logic [DATAWIDTH-1:0] req1_sh;
    logic                 req1_ready;

    logic                 rsp_valid;
    logic [DATAWIDTH-1:0] rsp_d;
    logic                 rsp_id;
    logic                 rsp_ready;

    // Shifter side: takes requests, produces responses.
    modport slave (
        input  req0_valid, req0_a, req0_sh,
        output req0_ready,
        input  req1_valid, req1_a, req1_sh,
        output req1_ready,
        output rsp_valid, rsp_d, rsp_id,
        input  rsp_ready
    );

    // Producer/consumer side.
    modport master (
        output req0_valid, req0_a, req0_sh,
        input  req0_ready,
        output req1_valid, req1_a, req1_sh,
        input  req1_ready,
        input  rsp_valid, rsp_d, rsp_id,
        output rsp_ready
    );
endinterface

// File: rtl/sshr_share_ctrl.sv
// Shared iterative signed arithmetic right shifter. Two requesters are
// arbitrated round-robin; the winner's operand is shifted one bit per cycle
// (sign-filling) and the result is held on the response channel until the
// consumer takes it. Shift amounts at or above DATAWIDTH clamp to DATAWIDTH,
// which leaves only sign bits.
module sshr_share_ctrl #(
    parameter int DATAWIDTH = 8
) (
    input  logic                 Clk,
    input  logic                 Rst,
    sshr_share_ctrl_if.slave     bus,
    output logic                 busy,
    output logic [1:0]           dbg_state
);

    localparam int CW = $clog2(DATAWIDTH + 1);
    localparam logic [DATAWIDTH-1:0] SH_MAX  = DATAWIDTH'(DATAWIDTH);
    localparam logic [CW-1:0]        CNT_MAX = CW'(DATAWIDTH);
    localparam logic [CW-1:0]        CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nx;
    logic [DATAWIDTH-1:0] acc;
    logic [CW-1:0]        count;
    logic                 rsp_id_q;
    logic                 last_grant;

    logic                 any_valid;
    logic                 grant;
    logic                 accept;
    logic [DATAWIDTH-1:0] sel_a;
    logic [DATAWIDTH-1:0] sel_sh;
    logic [CW-1:0]        n_sel;

    // Round-robin pick: a lone requester wins, a tie goes to the one not
    // served last. Operand and clamped shift count of the winner.
    always_comb begin
        any_valid = bus.req0_valid | bus.req1_valid;
        grant     = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant = ~last_grant;
        end else if (bus.req1_valid) begin
            grant = 1'b1;
        end
        sel_a  = grant ? bus.req1_a  : bus.req0_a;
        sel_sh = grant ? bus.req1_sh : bus.req0_sh;
        if (sel_sh >= SH_MAX) begin
            n_sel = CNT_MAX;
        end else begin
            n_sel = CW'(sel_sh);
        end
        accept = (state == IDLE) && any_valid;
    end

    // State register.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: a zero shift goes straight to RESP; the last shift
    // edge lands in RESP so the result is registered when rsp_valid rises.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = (n_sel == '0) ? RESP : SHIFT;
                end
            end
            SHIFT: begin
                if (count == CNT_ONE) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Outputs decoded from state; ready only ever rises in IDLE, so no
    // request can be taken in the cycle a response is handed over.
    always_comb begin
        bus.req0_ready = accept && !grant;
        bus.req1_ready = accept &&  grant;
        bus.rsp_valid  = (state == RESP);
        bus.rsp_d      = acc;
        bus.rsp_id     = rsp_id_q;
        busy           = (state != IDLE);
        dbg_state      = state;
    end

    // Datapath: load on accept, shift one bit per SHIFT cycle, hold in RESP.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            acc        <= '0;
            count      <= '0;
            rsp_id_q   <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc        <= sel_a;
                        count      <= n_sel;
                        rsp_id_q   <= grant;
                        last_grant <= grant;
                    end
                end
                SHIFT: begin
                    acc   <= {acc[DATAWIDTH-1], acc[DATAWIDTH-1:1]};
                    count <= count - CNT_ONE;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
